montprod_operand_mem: RTL and testbench
=======================================

MONTPROD_OPERAND_MEM -- requirements
Module: montprod_operand_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: word address width (256 words per bank).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port host_cs  in  1: host access strobe.
REQ-006 SHALL have port host_we  in  1: host write when high, read when low.
REQ-007 SHALL have port host_bank  in  2: bank select, 0=A, 1=B, 2=M, 3=R.
REQ-008 SHALL have port host_addr  in  8: host word address.
REQ-009 SHALL have port host_wdata  in  32: host write data.
REQ-010 SHALL have port host_rdata  out  32: host read data, one-cycle latency.
REQ-011 SHALL have port length  in  8: operand length in words, sampled on accepted start.
REQ-012 SHALL have port start  in  1: single-cycle job request.
REQ-013 SHALL have port copy_result  in  1: sampled with start; copy R to A after the product.
REQ-014 SHALL have port busy  out  1: job in progress.
REQ-015 SHALL have port done  out  1: one-cycle job-complete pulse.
REQ-016 SHALL have port access_error  out  1: sticky flag for a host access while busy.
REQ-017 SHALL have port calculate  out  1: start pulse to montprod.
REQ-018 SHALL have port ready  in  1: ready from montprod.
REQ-019 SHALL have ports opa_addr, opb_addr, opm_addr  in  8 each: montprod operand read addresses.
REQ-020 SHALL have ports opa_data, opb_data, opm_data  out  32 each: registered read data from banks A/B/M.
REQ-021 SHALL have ports result_addr  in  8, result_data  in  32, result_we  in  1: montprod result write into bank R.

Function
REQ-022 SHALL update opX_data every cycle to bank[opX_addr] as sampled at the previous edge (latency 1), independent of FSM state.
REQ-023 SHALL read the old word when the same address is read and written in the same cycle.
REQ-024 SHALL write R[result_addr] <= result_data on an edge with result_we=1 only in state WAIT_LOW or WAIT_HIGH; otherwise the write is ignored.
REQ-025 SHALL accept host writes only in IDLE: host_cs=1 and host_we=1 write host_bank[host_addr].
REQ-026 SHALL, in IDLE, drive host_rdata one cycle after host_cs=1 and host_we=0 to the addressed word; otherwise host_rdata holds its last value.
REQ-027 SHALL, for any host_cs=1 while busy=1, drop the access, set host_rdata to 0 for a read, and set access_error; access_error clears only on an accepted start or on reset.
REQ-028 SHALL implement the FSM states IDLE, CALC, WAIT_LOW, WAIT_HIGH, COPY and DONE.
REQ-029 SHALL, in IDLE with start=1, latch length and copy_result and go to CALC; if length=0, go directly to DONE.
REQ-030 SHALL, in CALC, assert calculate for exactly one cycle and then go to WAIT_LOW.
REQ-031 SHALL remain in WAIT_LOW until ready=0 is observed, then go to WAIT_HIGH.
REQ-032 SHALL remain in WAIT_HIGH until ready=1 is observed, then go to COPY if the copy flag is set, else to DONE.
REQ-033 SHALL, in COPY, read R[i] and write A[i] one cycle later for i = 0 .. length-1; COPY lasts length+1 cycles.
REQ-034 SHALL, in DONE, assert done for one cycle and then return to IDLE.
REQ-035 SHALL hold busy=1 in every state except IDLE, from the cycle after an accepted start.
REQ-036 SHALL ignore start when not in IDLE; start asserted together with a host access in IDLE SHALL complete the access and then start the job.
REQ-037 SHALL treat length as unsigned, with 255 as the maximum; the copy counter SHALL not wrap.

Reset
REQ-038 SHALL, on reset, set the FSM to IDLE and clear busy, done, calculate, access_error, host_rdata and opa/opb/opm_data to 0 at the same edge, including when reset occurs mid-job.
REQ-039 SHALL NOT clear bank contents on reset; contents are unspecified after power-up.

Structure
REQ-040 SHALL take bank codes, FSM state encoding and ADDR_WIDTH/DATA_WIDTH defaults from a shared package montprod_pkg.
REQ-041 SHALL instantiate a sub-module montprod_bank (1 write port, 2 registered read ports, 256x32) four times, one per bank.

Verification
REQ-042 SHALL cover: load A[0]=9, B[0]=7, M[0]=0x13, length=1, start with montprod attached -> one calculate pulse, then done, and a host read of R[0] returns 0x1.
REQ-043 SHALL cover: same operands plus copy_result=1 -> A[0]=0x1 after done; COPY lasts 2 cycles.
REQ-044 SHALL cover: host write to B[5] during WAIT_HIGH -> B[5] unchanged, access_error=1, and the next start clears it.
REQ-045 SHALL cover: start with length=0 -> no calculate, done the cycle after CALC would have occurred, busy high for exactly one cycle.
REQ-046 SHALL cover: reset asserted in WAIT_LOW -> busy, calculate and done are 0 at the next edge, and a previously loaded M[0]=0x13 reads back intact.
REQ-047 SHALL cover: result_we=1 while IDLE with result_addr=3 -> R[3] unchanged.

Source files
------------

// File: rtl/montprod_pkg.sv
// Shared definitions for the Montgomery product operand memory: bank codes,
// FSM state encoding and default geometry.
package montprod_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int NUM_BANKS          = 4;

    // Host bank select codes
    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_M = 2'd2;
    localparam logic [1:0] BANK_R = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CALC      = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_COPY      = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // The multiplier may only write its result while we are waiting on it
    function automatic logic result_write_open(input state_e s);
        return (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
    endfunction

endpackage

// File: rtl/montprod_bank.sv
// One operand bank: a single write port and two registered read ports.
// Port 0 reads every cycle; port 1 only updates when enabled so it can hold
// the last host read value.
module montprod_bank
    import montprod_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd0_data_q;
    logic [DATA_WIDTH-1:0] rd1_data_q;

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered reads return the pre-write word on a same-address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_data_q <= '0;
            rd1_data_q <= '0;
        end else begin
            rd0_data_q <= mem_q[rd0_addr];
            if (rd1_en) begin
                rd1_data_q <= mem_q[rd1_addr];
            end
        end
    end

    assign rd0_data = rd0_data_q;
    assign rd1_data = rd1_data_q;

endmodule

// File: rtl/montprod_operand_mem.sv
// Operand memory and job sequencer for a Montgomery multiplier: four banks
// (A, B, M, R), host access while idle, calculate/ready handshake and an
// optional copy of the result bank back into A.
module montprod_operand_mem
    import montprod_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_cs,
    input  logic                  host_we,
    input  logic [1:0]            host_bank,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  start,
    input  logic                  copy_result,
    output logic                  busy,
    output logic                  done,
    output logic                  access_error,
    output logic                  calculate,
    input  logic                  ready,
    input  logic [ADDR_WIDTH-1:0] opa_addr,
    input  logic [ADDR_WIDTH-1:0] opb_addr,
    input  logic [ADDR_WIDTH-1:0] opm_addr,
    output logic [DATA_WIDTH-1:0] opa_data,
    output logic [DATA_WIDTH-1:0] opb_data,
    output logic [DATA_WIDTH-1:0] opm_data,
    input  logic [ADDR_WIDTH-1:0] result_addr,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  result_we
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  copy_q, copy_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;      // one bit wider so 255 never wraps
    logic                  err_q, err_d;
    logic                  rzero_q, rzero_d;  // host_rdata forced to zero
    logic [1:0]            rsel_q, rsel_d;    // bank of the last accepted host read

    logic                  idle;
    logic                  host_wr;
    logic                  host_rd;
    logic                  copy_wr;
    logic [ADDR_WIDTH:0]   cnt_prev;

    logic                  bank_we     [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_waddr  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata  [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_raddr0 [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata0 [NUM_BANKS];
    logic                  bank_ren1   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata1 [NUM_BANKS];

    assign idle     = (state_q == ST_IDLE);
    assign host_wr  = idle && host_cs && host_we;
    assign host_rd  = idle && host_cs && !host_we;
    assign copy_wr  = (state_q == ST_COPY) && (cnt_q != '0);
    assign cnt_prev = cnt_q - {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Bank port steering: host writes, copy writes into A, result writes into R
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]    = host_wr && (host_bank == 2'(b));
            bank_waddr[b] = host_addr;
            bank_wdata[b] = host_wdata;
            bank_ren1[b]  = host_rd && (host_bank == 2'(b));
        end
        if (copy_wr) begin
            bank_we[BANK_A]    = 1'b1;
            bank_waddr[BANK_A] = cnt_prev[ADDR_WIDTH-1:0];
            bank_wdata[BANK_A] = bank_rdata0[BANK_R];
        end
        if (result_we && result_write_open(state_q)) begin
            bank_we[BANK_R]    = 1'b1;
            bank_waddr[BANK_R] = result_addr;
            bank_wdata[BANK_R] = result_data;
        end
        bank_raddr0[BANK_A] = opa_addr;
        bank_raddr0[BANK_B] = opb_addr;
        bank_raddr0[BANK_M] = opm_addr;
        bank_raddr0[BANK_R] = cnt_q[ADDR_WIDTH-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            montprod_bank #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_bank (
                .clk     (clk),
                .reset   (reset),
                .we      (bank_we[gi]),
                .waddr   (bank_waddr[gi]),
                .wdata   (bank_wdata[gi]),
                .rd0_addr(bank_raddr0[gi]),
                .rd0_data(bank_rdata0[gi]),
                .rd1_en  (bank_ren1[gi]),
                .rd1_addr(host_addr),
                .rd1_data(bank_rdata1[gi])
            );
        end
    endgenerate

    // Next-state, job latches, copy counter and host access bookkeeping
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        copy_d  = copy_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rzero_d = rzero_q;
        rsel_d  = rsel_q;

        if (host_rd) begin
            rsel_d  = host_bank;
            rzero_d = 1'b0;
        end else if (host_cs && !idle) begin
            rzero_d = 1'b1;
            err_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = length;
                    copy_d  = copy_result;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (length == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW:  if (!ready) state_d = ST_WAIT_HIGH;
            ST_WAIT_HIGH: begin
                if (ready) begin
                    cnt_d   = '0;
                    state_d = copy_q ? ST_COPY : ST_DONE;
                end
            end
            ST_COPY: begin
                if (cnt_q == {1'b0, len_q}) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            copy_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
            rsel_q  <= BANK_A;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            copy_q  <= copy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rzero_q <= rzero_d;
            rsel_q  <= rsel_d;
        end
    end

    assign busy         = !idle;
    assign done         = (state_q == ST_DONE);
    assign calculate    = (state_q == ST_CALC);
    assign access_error = err_q;
    assign host_rdata   = rzero_q ? '0 : bank_rdata1[rsel_q];
    assign opa_data     = bank_rdata0[BANK_A];
    assign opb_data     = bank_rdata0[BANK_B];
    assign opm_data     = bank_rdata0[BANK_M];

endmodule

// File: tb/tb_montprod_operand_mem.sv
// Directed bench for montprod_operand_mem with a behavioural Montgomery
// multiplier driven inline from the stimulus sequence.
module tb_montprod_operand_mem;
    import montprod_pkg::*;

    logic        clk;
    logic        reset;
    logic        host_cs;
    logic        host_we;
    logic [1:0]  host_bank;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic [7:0]  length;
    logic        start;
    logic        copy_result;
    logic        busy;
    logic        done;
    logic        access_error;
    logic        calculate;
    logic        ready;
    logic [7:0]  opa_addr;
    logic [7:0]  opb_addr;
    logic [7:0]  opm_addr;
    logic [31:0] opa_data;
    logic [31:0] opb_data;
    logic [31:0] opm_data;
    logic [7:0]  result_addr;
    logic [31:0] result_data;
    logic        result_we;

    int checks = 0;
    int errors = 0;
    int calc_n = 0;
    int done_n = 0;
    int busy_n = 0;
    logic [31:0] rd;

    montprod_operand_mem dut (
        .clk         (clk),
        .reset       (reset),
        .host_cs     (host_cs),
        .host_we     (host_we),
        .host_bank   (host_bank),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .length      (length),
        .start       (start),
        .copy_result (copy_result),
        .busy        (busy),
        .done        (done),
        .access_error(access_error),
        .calculate   (calculate),
        .ready       (ready),
        .opa_addr    (opa_addr),
        .opb_addr    (opb_addr),
        .opm_addr    (opm_addr),
        .opa_data    (opa_data),
        .opb_data    (opb_data),
        .opm_data    (opm_data),
        .result_addr (result_addr),
        .result_data (result_data),
        .result_we   (result_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%08h", tag, got);
        end
    endtask

    // One clock; sample 1 ns after the edge and tally handshake outputs
    task automatic tick();
        @(posedge clk);
        #1;
        if (calculate) calc_n++;
        if (done)      done_n++;
        if (busy)      busy_n++;
    endtask

    task automatic clear_counts();
        calc_n = 0;
        done_n = 0;
        busy_n = 0;
    endtask

    task automatic host_write(input logic [1:0] bank, input logic [7:0] addr, input logic [31:0] data);
        host_cs = 1'b1; host_we = 1'b1; host_bank = bank; host_addr = addr; host_wdata = data;
        tick();
        host_cs = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] bank, input logic [7:0] addr, output logic [31:0] data);
        host_cs = 1'b1; host_we = 1'b0; host_bank = bank; host_addr = addr;
        tick();
        host_cs = 1'b0;
        data = host_rdata;
    endtask

    // Word-serial Montgomery product a*b*2^-32 mod m
    function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
        logic [95:0] t;
        t = 96'(a) * 96'(b);
        for (int i = 0; i < 32; i++) begin
            if (t[0]) t = t + 96'(m);
            t = t >> 1;
        end
        if (t >= 96'(m)) t = t - 96'(m);
        return t[31:0];
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) tick();
        check("job_returns_idle", {31'd0, busy}, 32'd0);
    endtask

    // Start a job and play the multiplier if it asks for a product
    task automatic run_job(input logic [7:0] len, input logic cp);
        clear_counts();
        length = len; copy_result = cp; start = 1'b1;
        tick();
        start = 1'b0;
        if (calculate) begin
            ready = 1'b0;
            tick();
            tick();
            result_addr = 8'd0;
            result_data = mont(opa_data, opb_data, opm_data);
            result_we = 1'b1;
            tick();
            result_we = 1'b0;
            ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        reset = 1'b1; host_cs = 1'b0; host_we = 1'b0; host_bank = 2'd0; host_addr = 8'd0;
        host_wdata = 32'd0; length = 8'd0; start = 1'b0; copy_result = 1'b0; ready = 1'b1;
        opa_addr = 8'd0; opb_addr = 8'd0; opm_addr = 8'd0;
        result_addr = 8'd0; result_data = 32'd0; result_we = 1'b0;

        // Reset state
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_calculate", {31'd0, calculate}, 32'd0);
        check("rst_access_error", {31'd0, access_error}, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_opa_data", opa_data, 32'd0);
        reset = 1'b0;
        tick();

        // Load operands
        host_write(BANK_A, 8'd0, 32'd9);
        host_write(BANK_B, 8'd0, 32'd7);
        host_write(BANK_M, 8'd0, 32'h13);
        host_read(BANK_A, 8'd0, rd);
        check("readback_a0", rd, 32'd9);
        tick();
        check("operand_port_a0", opa_data, 32'd9);

        // Product without copy: 9*7*2^-32 mod 19 = 1
        run_job(8'd1, 1'b0);
        check("job1_calc_pulses", calc_n, 32'd1);
        check("job1_done_pulses", done_n, 32'd1);
        check("job1_busy_cycles", busy_n, 32'd5);
        host_read(BANK_R, 8'd0, rd);
        check("job1_r0", rd, 32'h1);
        tick(); tick();
        check("rdata_holds", host_rdata, 32'h1);

        // Same product with copy back into A: two extra COPY cycles
        run_job(8'd1, 1'b1);
        check("job2_calc_pulses", calc_n, 32'd1);
        check("job2_done_pulses", done_n, 32'd1);
        check("job2_busy_cycles", busy_n, 32'd7);
        host_read(BANK_A, 8'd0, rd);
        check("job2_a0_copied", rd, 32'h1);

        // Host access while busy is dropped and flagged
        host_write(BANK_B, 8'd5, 32'h55);
        length = 8'd1; copy_result = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        host_write(BANK_B, 8'd5, 32'hdead);
        check("busy_wr_access_error", {31'd0, access_error}, 32'd1);
        host_read(BANK_B, 8'd5, rd);
        check("busy_rd_zero", rd, 32'd0);
        ready = 1'b1;
        wait_idle();
        check("error_sticky_idle", {31'd0, access_error}, 32'd1);
        host_read(BANK_B, 8'd5, rd);
        check("b5_unchanged", rd, 32'h55);

        // Zero-length job, issued together with a host write
        clear_counts();
        length = 8'd0; start = 1'b1;
        host_cs = 1'b1; host_we = 1'b1; host_bank = BANK_A; host_addr = 8'd9; host_wdata = 32'h99;
        tick();
        start = 1'b0; host_cs = 1'b0; host_we = 1'b0;
        check("len0_error_cleared", {31'd0, access_error}, 32'd0);
        check("len0_done_now", {31'd0, done}, 32'd1);
        tick();
        check("len0_busy_cycles", busy_n, 32'd1);
        check("len0_calc_pulses", calc_n, 32'd0);
        check("len0_done_pulses", done_n, 32'd1);
        host_read(BANK_A, 8'd9, rd);
        check("start_with_write_a9", rd, 32'h99);

        // Reset while parked in WAIT_LOW (ready never drops)
        length = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wl_busy", {31'd0, busy}, 32'd1);
        check("wl_opa_data", opa_data, 32'h1);
        reset = 1'b1;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_calculate", {31'd0, calculate}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_opa_data", opa_data, 32'd0);
        check("midrst_host_rdata", host_rdata, 32'd0);
        reset = 1'b0;
        tick();
        host_read(BANK_M, 8'd0, rd);
        check("m0_survives_reset", rd, 32'h13);

        // Result write while idle is ignored
        host_write(BANK_R, 8'd3, 32'h33);
        result_addr = 8'd3; result_data = 32'hbad; result_we = 1'b1;
        tick();
        result_we = 1'b0;
        host_read(BANK_R, 8'd3, rd);
        check("idle_result_we_ignored", rd, 32'h33);

        // Same-address read and write returns the old word first
        host_write(BANK_A, 8'd7, 32'h11);
        opa_addr = 8'd7;
        host_write(BANK_A, 8'd7, 32'h22);
        check("rw_collision_old", opa_data, 32'h11);
        tick();
        check("rw_collision_new", opa_data, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
